// File: rtl/auto_nav_ctrl_pkg.sv
// Shared definitions for the autonomous navigation sequencer: state encodings,
// detector bit positions and default timing constants.
package auto_nav_ctrl_pkg;

    typedef enum logic [2:0] {
        NAV_IDLE    = 3'd0,
        NAV_SETTLE  = 3'd1,
        NAV_DECIDE  = 3'd2,
        NAV_FORWARD = 3'd3,
        NAV_TURN    = 3'd4,
        NAV_BEACON  = 3'd5
    } nav_state_t;

    localparam int DET_FRONT = 0;
    localparam int DET_LEFT  = 1;
    localparam int DET_RIGHT = 2;
    localparam int DET_BACK  = 3;

    localparam int DEF_TURN90_MS  = 900;
    localparam int DEF_TURN180_MS = 1800;
    localparam int DEF_FWD_MIN_MS = 500;
    localparam int DEF_DEB_MS     = 20;
    localparam int DEF_BEACON_EN  = 1;

    localparam int MS_W = 16;

endpackage

// File: rtl/auto_nav_ctrl_det_debounce.sv
// Two-flop synchronizer plus per-bit debounce for the four obstacle detectors.
// A bit is accepted only after differing from the held value for DEB_MS ticks.
module det_debounce #(
    parameter int DEB_MS = 20
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       tick_ms,
    input  logic [3:0] det,
    output logic [3:0] det_db
);

    localparam int CW = (DEB_MS > 1) ? $clog2(DEB_MS) : 1;

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [CW-1:0] cnt [4];

    // Synchronizers reset to "blocked" so no bit starts counting out of reset.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            sync1  <= 4'b1111;
            sync2  <= 4'b1111;
            det_db <= 4'b1111;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= det;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == det_db[i]) begin
                    cnt[i] <= '0;
                end else if (tick_ms) begin
                    if (cnt[i] == CW'(DEB_MS - 1)) begin
                        det_db[i] <= sync2[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/auto_nav_ctrl.sv
// Autonomous right-hand-wall driving sequencer with timed turns, paced by the
// 1 ms tick; drives the same command bits as the manual and semi-auto paths.
module auto_nav_ctrl
    import auto_nav_ctrl_pkg::*;
#(
    parameter int TURN90_MS  = DEF_TURN90_MS,
    parameter int TURN180_MS = DEF_TURN180_MS,
    parameter int FWD_MIN_MS = DEF_FWD_MIN_MS,
    parameter int DEB_MS     = DEF_DEB_MS,
    parameter int BEACON_EN  = DEF_BEACON_EN
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       tick_ms,
    input  logic [3:0] det,
    output logic       move_forward,
    output logic       turn_left,
    output logic       turn_right,
    output logic       place_barrier,
    output logic [2:0] nav_state,
    output logic [7:0] turn_count
);

    nav_state_t      state;
    logic            tick_arm;
    logic            tick;
    logic            enable_q;
    logic            turn_is_left;
    logic [MS_W-1:0] ms_cnt;
    logic [MS_W-1:0] guard_cnt;
    logic [3:0]      det_db;
    logic            unused_back;

    // A tick landing on the first edge after reset release is discarded.
    assign tick        = tick_ms & tick_arm;
    assign nav_state   = state;
    assign unused_back = det_db[DET_BACK];

    det_debounce #(
        .DEB_MS (DEB_MS)
    ) u_det_debounce (
        .sys_clk (sys_clk),
        .rst     (rst),
        .tick_ms (tick),
        .det     (det),
        .det_db  (det_db)
    );

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state         <= NAV_IDLE;
            tick_arm      <= 1'b0;
            enable_q      <= 1'b0;
            turn_is_left  <= 1'b0;
            ms_cnt        <= '0;
            guard_cnt     <= '0;
            turn_count    <= '0;
            move_forward  <= 1'b0;
            turn_left     <= 1'b0;
            turn_right    <= 1'b0;
            place_barrier <= 1'b0;
        end else begin
            tick_arm      <= 1'b1;
            enable_q      <= enable;
            // Commands follow the state one clock later, and drop with enable.
            move_forward  <= enable && (state == NAV_FORWARD);
            turn_left     <= enable && (state == NAV_TURN) && turn_is_left;
            turn_right    <= enable && (state == NAV_TURN) && !turn_is_left;
            place_barrier <= enable && (state == NAV_BEACON);

            if (!enable) begin
                state        <= NAV_IDLE;
                ms_cnt       <= '0;
                guard_cnt    <= '0;
                turn_is_left <= 1'b0;
            end else begin
                case (state)
                    NAV_IDLE: begin
                        if (!enable_q) begin
                            state  <= NAV_SETTLE;
                            ms_cnt <= MS_W'(DEB_MS + 2);
                        end
                    end
                    NAV_SETTLE: begin
                        if (tick) begin
                            if (ms_cnt <= MS_W'(1)) begin
                                state  <= NAV_DECIDE;
                                ms_cnt <= '0;
                            end else begin
                                ms_cnt <= ms_cnt - 1'b1;
                            end
                        end
                    end
                    NAV_DECIDE: begin
                        if (!det_db[DET_RIGHT]) begin
                            state        <= NAV_TURN;
                            turn_is_left <= 1'b0;
                            ms_cnt       <= MS_W'(TURN90_MS);
                        end else if (!det_db[DET_FRONT]) begin
                            state     <= NAV_FORWARD;
                            guard_cnt <= '0;
                        end else if (!det_db[DET_LEFT]) begin
                            state        <= NAV_TURN;
                            turn_is_left <= 1'b1;
                            ms_cnt       <= MS_W'(TURN90_MS);
                        end else begin
                            state        <= NAV_TURN;
                            turn_is_left <= 1'b0;
                            ms_cnt       <= MS_W'(TURN180_MS);
                        end
                    end
                    NAV_FORWARD: begin
                        if (tick && (guard_cnt != '0)) begin
                            guard_cnt <= guard_cnt - 1'b1;
                        end
                        if (det_db[DET_FRONT] ||
                            (!det_db[DET_RIGHT] && (guard_cnt == '0))) begin
                            state <= NAV_DECIDE;
                        end
                    end
                    NAV_TURN: begin
                        if (tick) begin
                            if (ms_cnt <= MS_W'(1)) begin
                                turn_count <= turn_count + 1'b1;
                                ms_cnt     <= '0;
                                if (BEACON_EN != 0) begin
                                    state <= NAV_BEACON;
                                end else begin
                                    state     <= NAV_FORWARD;
                                    guard_cnt <= MS_W'(FWD_MIN_MS);
                                end
                            end else begin
                                ms_cnt <= ms_cnt - 1'b1;
                            end
                        end
                    end
                    NAV_BEACON: begin
                        if (tick) begin
                            state     <= NAV_FORWARD;
                            guard_cnt <= MS_W'(FWD_MIN_MS);
                        end
                    end
                    default: begin
                        state <= NAV_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
